// File: rtl/sram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared definitions for the SRAM bank controller slice:
//   - OCP-style command codes (IDLE/WR/RD) and response codes (NULL/DVA/ERR)
//   - default macro geometry (32-bit word, 256 words, 4 mask bits)
//   - controller FSM state type and the bank-select width helper
// -----------------------------------------------------------------------------
package sram_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_WORDS      = 256;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_MASK_BITS  = 4;

  localparam logic [2:0] OCP_CMD_IDLE = 3'b000;
  localparam logic [2:0] OCP_CMD_WR   = 3'b001;
  localparam logic [2:0] OCP_CMD_RD   = 3'b010;

  localparam logic [1:0] OCP_RESP_NULL = 2'b00;
  localparam logic [1:0] OCP_RESP_DVA  = 2'b01;
  localparam logic [1:0] OCP_RESP_ERR  = 2'b11;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_t;

  // A single macro still needs one bank bit so the address layout stays uniform.
  function automatic int bank_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_bank_decode.sv
// -----------------------------------------------------------------------------
// sram_bank_decode
// Purely combinational split of a byte address into macro word address and
// bank index, with a range check and per-bank active-low chip selects.
//   addr    : byte address, bits [1:0] ignored
//   req     : an access is wanted this cycle
//   word    : word address inside the macro
//   bank    : bank index (may be out of range when NUM_BANKS is not 2^n)
//   bank_ok : bank < NUM_BANKS
//   csb     : one-hot-low chip select, all ones unless req && bank_ok
// -----------------------------------------------------------------------------
module sram_bank_decode
  import sram_ctrl_pkg::*;
#(
  parameter int NUM_BANKS  = 2,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int BANK_BITS  = bank_bits(NUM_BANKS)
) (
  input  logic [ADDR_WIDTH+BANK_BITS+1:0] addr,
  input  logic                            req,
  output logic [ADDR_WIDTH-1:0]           word,
  output logic [BANK_BITS-1:0]            bank,
  output logic                            bank_ok,
  output logic [NUM_BANKS-1:0]            csb
);

  localparam int CMP_W = BANK_BITS + 1;

  assign word = addr[ADDR_WIDTH+1:2];
  assign bank = addr[ADDR_WIDTH+BANK_BITS+1:ADDR_WIDTH+2];

  // Extra MSB keeps the compare meaningful when NUM_BANKS == 2^BANK_BITS.
  assign bank_ok = ({1'b0, bank} < CMP_W'(NUM_BANKS));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_csb
      assign csb[gi] = !(req && bank_ok && (bank == BANK_BITS'(gi)));
    end
  endgenerate

  // Byte-lane bits carry no meaning for word accesses.
  logic unused_byte_bits;
  assign unused_byte_bits = ^addr[1:0];

endmodule

// File: rtl/sram_bank_ctrl.sv
// -----------------------------------------------------------------------------
// sram_bank_ctrl
// Initiator for NUM_BANKS 1RW+1R SRAM macros behind an OCP-style word port.
// One command per cycle, response (DVA/ERR) registered and valid in T+1.
//   clock, reset       : single clock, synchronous active-high reset
//   m_cmd/m_addr/...   : core command (IDLE/WR/RD), byte address, data, byte en
//   s_cmd_accept       : command taken this cycle
//   s_resp / s_data    : response code and read data (data valid on DVA after RD)
//   sram_*0            : port 0 of every macro (csb per bank, rest shared)
//   sram_dout0         : concatenated macro read data, bank 0 in the LSBs
//   sram_csb1          : port 1 chip selects, parked high
// Optional build macro SRAM_BANK_CTRL_INIT_EN: after reset, zero every word of
// every bank (one per cycle) before accepting commands.
// -----------------------------------------------------------------------------
module sram_bank_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int NUM_BANKS  = 2,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BANK_BITS  = bank_bits(NUM_BANKS)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [2:0]                      m_cmd,
  input  logic [ADDR_WIDTH+BANK_BITS+1:0] m_addr,
  input  logic [DATA_WIDTH-1:0]           m_data,
  input  logic [DATA_WIDTH/8-1:0]         m_byte_en,
  output logic                            s_cmd_accept,
  output logic [1:0]                      s_resp,
  output logic [DATA_WIDTH-1:0]           s_data,
  output logic [NUM_BANKS-1:0]            sram_csb0,
  output logic                            sram_web0,
  output logic [DATA_WIDTH/8-1:0]         sram_wmask0,
  output logic [ADDR_WIDTH-1:0]           sram_addr0,
  output logic [DATA_WIDTH-1:0]           sram_din0,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] sram_dout0,
  output logic [NUM_BANKS-1:0]            sram_csb1
);

  localparam int MADDR_W = ADDR_WIDTH + BANK_BITS + 2;

  ctrl_state_t            state_reg, state_next;
  logic [1:0]             resp_reg, resp_next;
  logic                   rd_reg, rd_next;
  logic [BANK_BITS-1:0]   bank_reg;

  logic                   cmd_rd, cmd_wr, be_any, run_req, dec_req, dec_bank_ok;
  logic [MADDR_W-1:0]     dec_addr;
  logic [ADDR_WIDTH-1:0]  dec_word;
  logic [BANK_BITS-1:0]   dec_bank;

  assign cmd_rd  = (m_cmd == OCP_CMD_RD);
  assign cmd_wr  = (m_cmd == OCP_CMD_WR);
  assign be_any  = |m_byte_en;
  // A WR with no enabled byte is acknowledged but never touches a macro.
  assign run_req = (state_reg == ST_RUN) && (cmd_rd || (cmd_wr && be_any));

`ifdef SRAM_BANK_CTRL_INIT_EN
  localparam int CNT_W = ADDR_WIDTH + BANK_BITS;
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(NUM_BANKS * (1 << ADDR_WIDTH) - 1);
  localparam ctrl_state_t RESET_STATE = ST_INIT;

  logic [CNT_W-1:0] init_cnt_reg;

  // Counter upper bits are the bank, lower bits the word: reuse the decoder.
  assign dec_addr = (state_reg == ST_INIT) ? {init_cnt_reg, 2'b00} : m_addr;
  assign dec_req  = !reset && ((state_reg == ST_INIT) || run_req);

  always_ff @(posedge clock) begin
    if (reset) begin
      init_cnt_reg <= '0;
    end else if (state_reg == ST_INIT) begin
      init_cnt_reg <= init_cnt_reg + CNT_W'(1);
    end
  end
`else
  localparam ctrl_state_t RESET_STATE = ST_RUN;

  assign dec_addr = m_addr;
  assign dec_req  = !reset && run_req;
`endif

  sram_bank_decode #(
    .NUM_BANKS  (NUM_BANKS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BANK_BITS  (BANK_BITS)
  ) u_decode (
    .addr    (dec_addr),
    .req     (dec_req),
    .word    (dec_word),
    .bank    (dec_bank),
    .bank_ok (dec_bank_ok),
    .csb     (sram_csb0)
  );

  // Port-0 drive is combinational so the macro samples it at the edge ending T.
  always_comb begin
    state_next   = state_reg;
    s_cmd_accept = 1'b0;
    sram_web0    = 1'b1;
    sram_wmask0  = '0;
    sram_addr0   = '0;
    sram_din0    = '0;
    resp_next    = OCP_RESP_NULL;
    rd_next      = 1'b0;
    if (!reset) begin
      case (state_reg)
        ST_RUN: begin
          s_cmd_accept = 1'b1;
          if (cmd_rd || cmd_wr) begin
            resp_next = dec_bank_ok ? OCP_RESP_DVA : OCP_RESP_ERR;
            if (dec_bank_ok) begin
              if (cmd_rd) begin
                sram_addr0 = dec_word;
                rd_next    = 1'b1;
              end else if (be_any) begin
                sram_addr0  = dec_word;
                sram_web0   = 1'b0;
                sram_wmask0 = m_byte_en;
                sram_din0   = m_data;
              end
            end
          end
        end
        default: begin
`ifdef SRAM_BANK_CTRL_INIT_EN
          sram_web0   = 1'b0;
          sram_wmask0 = '1;
          sram_addr0  = dec_word;
          if (init_cnt_reg == INIT_LAST) state_next = ST_RUN;
`else
          state_next = ST_RUN;
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= RESET_STATE;
      resp_reg  <= OCP_RESP_NULL;
      rd_reg    <= 1'b0;
      bank_reg  <= '0;
    end else begin
      state_reg <= state_next;
      resp_reg  <= resp_next;
      rd_reg    <= rd_next;
      if (rd_next) bank_reg <= dec_bank;
    end
  end

  assign s_resp    = resp_reg;
  assign sram_csb1 = '1;

  // Macro output is only meaningful in the cycle after its read.
  always_comb begin
    s_data = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (rd_reg && (bank_reg == BANK_BITS'(i))) begin
        s_data = sram_dout0[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_sram_bank_ctrl.sv
module tb_sram_bank_ctrl;

  localparam int NB   = 2;
  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int MW   = 4;
  localparam int MAW  = AW + 1 + 2;  // 11-bit byte address for 2 banks
  localparam int NB3  = 3;
  localparam int MAW3 = AW + 2 + 2;  // 12-bit byte address for 3 banks

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- main DUT (2 banks) ----------------
  logic            reset;
  logic [2:0]      m_cmd;
  logic [MAW-1:0]  m_addr;
  logic [DW-1:0]   m_data;
  logic [MW-1:0]   m_byte_en;
  logic            s_cmd_accept;
  logic [1:0]      s_resp;
  logic [DW-1:0]   s_data;
  logic [NB-1:0]   sram_csb0;
  logic            sram_web0;
  logic [MW-1:0]   sram_wmask0;
  logic [AW-1:0]   sram_addr0;
  logic [DW-1:0]   sram_din0;
  logic [NB*DW-1:0] sram_dout0;
  logic [NB-1:0]   sram_csb1;

  sram_bank_ctrl dut (
    .clock(clock), .reset(reset), .m_cmd(m_cmd), .m_addr(m_addr), .m_data(m_data),
    .m_byte_en(m_byte_en), .s_cmd_accept(s_cmd_accept), .s_resp(s_resp), .s_data(s_data),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
    .sram_csb1(sram_csb1)
  );

  // ---------------- second DUT (3 banks, out-of-range bank 3) ----------------
  logic [2:0]       m3_cmd;
  logic [MAW3-1:0]  m3_addr;
  logic [DW-1:0]    m3_data;
  logic [MW-1:0]    m3_byte_en;
  logic             s3_cmd_accept;
  logic [1:0]       s3_resp;
  logic [DW-1:0]    s3_data;
  logic [NB3-1:0]   s3_csb0;
  logic             s3_web0;
  logic [MW-1:0]    s3_wmask0;
  logic [AW-1:0]    s3_addr0;
  logic [DW-1:0]    s3_din0;
  logic [NB3*DW-1:0] s3_dout0;
  logic [NB3-1:0]   s3_csb1;

  assign s3_dout0 = {32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0};

  sram_bank_ctrl #(.NUM_BANKS(3)) dut3 (
    .clock(clock), .reset(reset), .m_cmd(m3_cmd), .m_addr(m3_addr), .m_data(m3_data),
    .m_byte_en(m3_byte_en), .s_cmd_accept(s3_cmd_accept), .s_resp(s3_resp), .s_data(s3_data),
    .sram_csb0(s3_csb0), .sram_web0(s3_web0), .sram_wmask0(s3_wmask0),
    .sram_addr0(s3_addr0), .sram_din0(s3_din0), .sram_dout0(s3_dout0),
    .sram_csb1(s3_csb1)
  );

  // ---------------- behavioural SRAM macros for the main DUT ----------------
  logic [DW-1:0] mem [NB][256];
  logic [DW-1:0] dout_q [NB];
  logic          fill_mem;
  logic [DW-1:0] fill_val;

  always @(posedge clock) begin
    for (int b = 0; b < NB; b++) begin
      if (fill_mem) begin
        for (int w = 0; w < 256; w++) mem[b][w] <= fill_val;
        dout_q[b] <= '0;
      end else if (!sram_csb0[b]) begin
        if (!sram_web0) begin
          for (int k = 0; k < MW; k++)
            if (sram_wmask0[k]) mem[b][sram_addr0][8*k +: 8] <= sram_din0[8*k +: 8];
        end else begin
          dout_q[b] <= mem[b][sram_addr0];
        end
      end
    end
  end

  assign sram_dout0 = {dout_q[1], dout_q[0]};

  // ---------------- reference model and checking ----------------
  logic [DW-1:0] ref_mem [NB*256];
  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Issue one command on the main DUT and check same-cycle port-0 drive and
  // the T+1 response. Called with inputs changed just after a rising edge.
  task automatic issue(input logic [2:0] cmd, input logic [MAW-1:0] addr,
                       input logic [DW-1:0] data, input logic [MW-1:0] be);
    int            idx;
    int            bank;
    logic          rd, wr, acc, wacc;
    logic [NB-1:0] exp_csb;
    logic [1:0]    exp_resp;
    logic [DW-1:0] exp_data;
    idx  = int'(addr[MAW-1:2]);
    bank = idx / 256;
    rd   = (cmd == 3'b010);
    wr   = (cmd == 3'b001);
    wacc = wr && (be != 0);
    acc  = rd || wacc;
    exp_csb = '1;
    if (acc) exp_csb[bank] = 1'b0;
    m_cmd = cmd; m_addr = addr; m_data = data; m_byte_en = be;
    #2;
    check_val("accept", s_cmd_accept, 1'b1);
    check_val("csb0", sram_csb0, exp_csb);
    check_val("web0", sram_web0, !wacc);
    if (acc) check_val("addr0", sram_addr0, idx % 256);
    if (wacc) begin
      check_val("wmask0", sram_wmask0, be);
      check_val("din0", sram_din0, data);
    end
    exp_resp = (rd || wr) ? 2'b01 : 2'b00;
    exp_data = rd ? ref_mem[idx] : '0;
    if (wr)
      for (int k = 0; k < MW; k++)
        if (be[k]) ref_mem[idx][8*k +: 8] = data[8*k +: 8];
    @(posedge clock); #1;
    check_val("resp", s_resp, exp_resp);
    check_val("rdata", s_data, exp_data);
    $display("txn cmd=%0d addr=%03h be=%h data=%08h -> resp=%0d rdata=%08h",
             cmd, addr, be, data, s_resp, s_data);
  endtask

  task automatic issue3(input logic [2:0] cmd, input logic [MAW3-1:0] addr,
                        input logic [NB3-1:0] exp_csb, input logic [1:0] exp_resp,
                        input logic [DW-1:0] exp_data);
    m3_cmd = cmd; m3_addr = addr; m3_data = 32'h5A5A5A5A; m3_byte_en = 4'hF;
    #2;
    check_val("b3_csb0", s3_csb0, exp_csb);
    @(posedge clock); #1;
    check_val("b3_resp", s3_resp, exp_resp);
    check_val("b3_rdata", s3_data, exp_data);
    $display("txn3 cmd=%0d addr=%03h -> resp=%0d rdata=%08h", cmd, addr, s3_resp, s3_data);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [2:0] rc;
    int r;

    reset = 1'b1;
    // A live command during reset must not leak through to the macros.
    m_cmd = 3'b001; m_addr = '0; m_data = 32'hFFFFFFFF; m_byte_en = 4'hF;
    m3_cmd = 3'b000; m3_addr = '0; m3_data = '0; m3_byte_en = '0;
    for (int i = 0; i < NB*256; i++) ref_mem[i] = '0;
`ifdef SRAM_BANK_CTRL_INIT_EN
    fill_val = 32'hA5A5A5A5;  // garbage that the sweep must clear
`else
    fill_val = 32'h00000000;
`endif
    fill_mem = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    fill_mem = 1'b0;
    check_val("rst_accept", s_cmd_accept, 1'b0);
    check_val("rst_resp", s_resp, 2'b00);
    check_val("rst_data", s_data, 32'h0);
    check_val("rst_csb0", sram_csb0, 2'b11);
    check_val("rst_web0", sram_web0, 1'b1);
    check_val("rst_wmask0", sram_wmask0, 4'h0);
    check_val("rst_addr0", sram_addr0, 8'h0);
    check_val("rst_din0", sram_din0, 32'h0);
    check_val("rst_csb1", sram_csb1, 2'b11);
    check_val("rst_b3_csb0", s3_csb0, 3'b111);
    m_cmd = 3'b000; m_byte_en = '0; m_data = '0;
    reset = 1'b0;
    #1;

`ifdef SRAM_BANK_CTRL_INIT_EN
    check_val("init_web0", sram_web0, 1'b0);
    check_val("init_wmask0", sram_wmask0, 4'hF);
    check_val("init_din0", sram_din0, 32'h0);
    check_val("init_csb0", sram_csb0, 2'b10);
    check_val("init_resp", s_resp, 2'b00);
    n = 0;
    while (!s_cmd_accept && n < 2000) begin
      @(posedge clock); #1;
      n++;
    end
    check_val("init_cycles", n, 512);
    // Each bank's last word must be cleared too.
    issue(3'b010, 11'h3FC, 32'h0, 4'h0);
    issue(3'b010, 11'h7FC, 32'h0, 4'h0);
`else
    check_val("accept_first", s_cmd_accept, 1'b1);
`endif

    // Directed cases.
    issue(3'b001, 11'h004, 32'hDEADBEEF, 4'hF);
    issue(3'b010, 11'h004, 32'h0, 4'h0);
    issue(3'b001, 11'h404, 32'hCAFEF00D, 4'hF);
    issue(3'b010, 11'h404, 32'h0, 4'h0);
    issue(3'b001, 11'h008, 32'h11223344, 4'h2);
    issue(3'b010, 11'h008, 32'h0, 4'h0);
    issue(3'b010, 11'h004, 32'h0, 4'h0);           // RD then WR same word: old data
    issue(3'b001, 11'h004, 32'h01020304, 4'h9);
    issue(3'b010, 11'h004, 32'h0, 4'h0);
    issue(3'b001, 11'h00C, 32'h77777777, 4'h0);    // no enabled byte: no access, DVA
    issue(3'b010, 11'h00C, 32'h0, 4'h0);
    issue(3'b000, 11'h004, 32'h0, 4'h0);           // idle
    issue(3'b101, 11'h404, 32'h0, 4'hF);           // unknown code behaves as idle
    issue(3'b110, 11'h004, 32'h0, 4'hF);

    // Randomized traffic on a small address window to force reuse.
    for (int t = 0; t < 200; t++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      rc = 3'b001;
      else if (r < 8) rc = 3'b010;
      else            rc = 3'($urandom_range(0, 7));
      issue(rc, {1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 2'($urandom_range(0, 3))},
            32'($urandom), 4'($urandom_range(0, 15)));
    end

    // Three-bank instance: bank 3 is out of range.
    n = 0;
    while (!s3_cmd_accept && n < 2000) begin
      @(posedge clock); #1;
      n++;
    end
    check_val("b3_accept", s3_cmd_accept, 1'b1);
    issue3(3'b010, 12'hC00, 3'b111, 2'b11, 32'h0);
    issue3(3'b010, 12'h800, 3'b011, 2'b01, 32'hC2C2C2C2);
    issue3(3'b010, 12'h404, 3'b101, 2'b01, 32'hB1B1B1B1);
    issue3(3'b001, 12'hC04, 3'b111, 2'b11, 32'h0);
    issue3(3'b010, 12'h000, 3'b110, 2'b01, 32'hA0A0A0A0);
    m3_cmd = 3'b000;

    // Reset in the cycle a RD is presented: response dropped.
    m_cmd = 3'b010; m_addr = 11'h004; m_byte_en = '0;
    reset = 1'b1;
    #2;
    check_val("rst_mid_accept", s_cmd_accept, 1'b0);
    check_val("rst_mid_csb0", sram_csb0, 2'b11);
    @(posedge clock); #1;
    reset = 1'b0;
    m_cmd = 3'b000;
    #1;
    check_val("rst_mid_resp", s_resp, 2'b00);
    check_val("rst_mid_data", s_data, 32'h0);
`ifndef SRAM_BANK_CTRL_INIT_EN
    check_val("rst_mid_csb0_after", sram_csb0, 2'b11);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
